// File: rtl/food_placer.sv
// ---------------------------------------------------------------------------
// food_placer
//
// Picks a free grid cell for the next piece of food. On a request it samples
// the free-running random coordinate source, rejects out-of-range
// candidates, and asks the occupancy map whether each in-range candidate is
// taken. It publishes the first free cell it finds. After MAX_TRIES failed
// random attempts it switches to a linear scan that starts one cell past the
// last candidate. The scan is bounded, so every request ends in either a
// placement (done) or a full-grid report (grid_full).
//
// Ports:
//   mclk, rst_n        clock, synchronous active-low reset
//   req                one-cycle placement request (ignored while busy)
//   ran_h, ran_v       random coordinates; low HW / VW bits are used
//   occ_rd             one-cycle occupancy query strobe
//   occ_h, occ_v       queried cell, held until the answer returns
//   occ_valid, occ_hit occupancy answer (hit = occupied)
//   busy               high whenever not idle
//   food_h, food_v     placed food position
//   food_valid         food position valid, held until the next request
//   done               one-cycle pulse on placement
//   grid_full          one-cycle pulse when no free cell exists
//
// Optional build macro FOOD_PLACER_STATS_EN adds:
//   last_attempts[15:0] queries issued for the most recent placement/full
//   scan_used           last result came from the linear scan
// ---------------------------------------------------------------------------
module food_placer #(
    parameter int H_CELLS   = 80,
    parameter int V_CELLS   = 60,
    parameter int HW        = 7,
    parameter int VW        = 6,
    parameter int MAX_TRIES = 16
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [31:0]   ran_h,
    input  logic [31:0]   ran_v,
    output logic          occ_rd,
    output logic [HW-1:0] occ_h,
    output logic [VW-1:0] occ_v,
    input  logic          occ_valid,
    input  logic          occ_hit,
    output logic          busy,
    output logic [HW-1:0] food_h,
    output logic [VW-1:0] food_v,
    output logic          food_valid,
    output logic          done,
    output logic          grid_full
`ifdef FOOD_PLACER_STATS_EN
    ,
    output logic [15:0]   last_attempts,
    output logic          scan_used
`endif
);

    localparam int CELLS  = H_CELLS * V_CELLS;
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int SCNT_W = $clog2(CELLS + 1);

    localparam logic [31:0]       H_LIM   = 32'(H_CELLS);
    localparam logic [31:0]       V_LIM   = 32'(V_CELLS);
    localparam logic [TRY_W-1:0]  MAX_C   = TRY_W'(MAX_TRIES);
    localparam logic [SCNT_W-1:0] CELLS_C = SCNT_W'(CELLS);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SAMPLE = 4'd1,
        ST_QUERY  = 4'd2,
        ST_WAIT   = 4'd3,
        ST_CHECK  = 4'd4,
        ST_SCAN_Q = 4'd5,
        ST_SCAN_W = 4'd6,
        ST_PLACE  = 4'd7,
        ST_FULL   = 4'd8
    } state_t;

    // True when (h, v) lies inside the playing field.
    function automatic logic in_range(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (32'(h) < H_LIM) && (32'(v) < V_LIM);
    endfunction

    // Raster-order successor of a cell, wrapping at the grid end. Anything
    // outside the grid maps to (0,0) so the scan always starts in range.
    function automatic logic [HW+VW-1:0] next_cell(input logic [HW-1:0] h, input logic [VW-1:0] v);
        logic [HW-1:0] nh;
        logic [VW-1:0] nv;
        if (!in_range(h, v)) begin
            nh = {HW{1'b0}};
            nv = {VW{1'b0}};
        end else if ((32'(h) + 32'd1) == H_LIM) begin
            nh = {HW{1'b0}};
            if ((32'(v) + 32'd1) == V_LIM) begin
                nv = {VW{1'b0}};
            end else begin
                nv = v + 1'b1;
            end
        end else begin
            nh = h + 1'b1;
            nv = v;
        end
        return {nv, nh};
    endfunction

    state_t              state_r;
    logic [HW-1:0]       cand_h_r;
    logic [VW-1:0]       cand_v_r;
    logic [TRY_W-1:0]    try_cnt_r;
    logic [SCNT_W-1:0]   scan_cnt_r;
    logic                occ_rd_r;
    logic                busy_r;
    logic [HW-1:0]       food_h_r;
    logic [VW-1:0]       food_v_r;
    logic                food_valid_r;
    logic                done_r;
    logic                grid_full_r;

    logic [HW-1:0]       ran_h_s;
    logic [VW-1:0]       ran_v_s;
    logic [HW-1:0]       nxt_h_s;
    logic [VW-1:0]       nxt_v_s;
    logic [TRY_W-1:0]    try_nxt_s;
    logic [SCNT_W-1:0]   scan_nxt_s;
    logic                unused_ran_s;

    assign ran_h_s            = ran_h[HW-1:0];
    assign ran_v_s            = ran_v[VW-1:0];
    assign {nxt_v_s, nxt_h_s} = next_cell(cand_h_r, cand_v_r);
    assign try_nxt_s          = try_cnt_r + 1'b1;
    assign scan_nxt_s         = scan_cnt_r + 1'b1;
    // Only the low coordinate bits of the random source are meaningful.
    assign unused_ran_s       = ^{ran_h[31:HW], ran_v[31:VW]};

    // Placement sequencer: state, candidate, counters and all registered outputs.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cand_h_r     <= {HW{1'b0}};
            cand_v_r     <= {VW{1'b0}};
            try_cnt_r    <= {TRY_W{1'b0}};
            scan_cnt_r   <= {SCNT_W{1'b0}};
            occ_rd_r     <= 1'b0;
            busy_r       <= 1'b0;
            food_h_r     <= {HW{1'b0}};
            food_v_r     <= {VW{1'b0}};
            food_valid_r <= 1'b0;
            done_r       <= 1'b0;
            grid_full_r  <= 1'b0;
        end else begin
            // Strobes are single-cycle; they are raised only on entry to
            // the state that owns them.
            occ_rd_r    <= 1'b0;
            done_r      <= 1'b0;
            grid_full_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r      <= ST_SAMPLE;
                        busy_r       <= 1'b1;
                        try_cnt_r    <= {TRY_W{1'b0}};
                        scan_cnt_r   <= {SCNT_W{1'b0}};
                        food_valid_r <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    cand_h_r <= ran_h_s;
                    cand_v_r <= ran_v_s;
                    if (in_range(ran_h_s, ran_v_s)) begin
                        state_r  <= ST_QUERY;
                        occ_rd_r <= 1'b1;
                    end else begin
                        // Out-of-range candidate burns a try without a query.
                        state_r <= ST_CHECK;
                    end
                end
                ST_QUERY: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (occ_valid) begin
                        if (!occ_hit) begin
                            state_r      <= ST_PLACE;
                            food_h_r     <= cand_h_r;
                            food_v_r     <= cand_v_r;
                            food_valid_r <= 1'b1;
                            done_r       <= 1'b1;
                        end else begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    try_cnt_r <= try_nxt_s;
                    if (try_nxt_s < MAX_C) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r    <= ST_SCAN_Q;
                        cand_h_r   <= nxt_h_s;
                        cand_v_r   <= nxt_v_s;
                        scan_cnt_r <= {SCNT_W{1'b0}};
                        occ_rd_r   <= 1'b1;
                    end
                end
                ST_SCAN_Q: begin
                    state_r <= ST_SCAN_W;
                end
                ST_SCAN_W: begin
                    if (occ_valid) begin
                        if (!occ_hit) begin
                            state_r      <= ST_PLACE;
                            food_h_r     <= cand_h_r;
                            food_v_r     <= cand_v_r;
                            food_valid_r <= 1'b1;
                            done_r       <= 1'b1;
                        end else begin
                            scan_cnt_r <= scan_nxt_s;
                            if (scan_nxt_s == CELLS_C) begin
                                // Every cell has been visited once and all are occupied.
                                state_r      <= ST_FULL;
                                grid_full_r  <= 1'b1;
                                food_valid_r <= 1'b0;
                            end else begin
                                state_r  <= ST_SCAN_Q;
                                cand_h_r <= nxt_h_s;
                                cand_v_r <= nxt_v_s;
                                occ_rd_r <= 1'b1;
                            end
                        end
                    end
                end
                ST_PLACE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                ST_FULL: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    food_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign occ_rd     = occ_rd_r;
    assign occ_h      = cand_h_r;
    assign occ_v      = cand_v_r;
    assign busy       = busy_r;
    assign food_h     = food_h_r;
    assign food_v     = food_v_r;
    assign food_valid = food_valid_r;
    assign done       = done_r;
    assign grid_full  = grid_full_r;

`ifdef FOOD_PLACER_STATS_EN
    // Saturating 16-bit increment so a huge grid cannot wrap the count.
    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        if (x == 16'hFFFF) begin
            return x;
        end else begin
            return x + 16'd1;
        end
    endfunction

    logic [15:0] qry_cnt_r;
    logic [15:0] last_attempts_r;
    logic        scan_used_r;

    // Count queries per request and latch the totals when the request completes.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            qry_cnt_r       <= 16'd0;
            last_attempts_r <= 16'd0;
            scan_used_r     <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && req) begin
                qry_cnt_r <= 16'd0;
            end else if (occ_rd_r) begin
                qry_cnt_r <= sat_inc16(qry_cnt_r);
            end else begin
                qry_cnt_r <= qry_cnt_r;
            end
            if (state_r == ST_PLACE) begin
                last_attempts_r <= qry_cnt_r;
                // The try counter only reaches MAX_TRIES on the way into the scan.
                scan_used_r     <= (try_cnt_r == MAX_C);
            end else if (state_r == ST_FULL) begin
                last_attempts_r <= qry_cnt_r;
                scan_used_r     <= 1'b1;
            end else begin
                last_attempts_r <= last_attempts_r;
                scan_used_r     <= scan_used_r;
            end
        end
    end

    assign last_attempts = last_attempts_r;
    assign scan_used     = scan_used_r;
`endif

endmodule

// File: tb/tb_food_placer.sv
module tb_food_placer;
    localparam int H  = 80;
    localparam int V  = 60;
    localparam int HW = 7;
    localparam int VW = 6;
    localparam int MT = 2;

    logic          mclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [31:0]   ran_h = 32'd0;
    logic [31:0]   ran_v = 32'd0;
    logic          occ_rd;
    logic [HW-1:0] occ_h;
    logic [VW-1:0] occ_v;
    logic          occ_valid = 1'b0;
    logic          occ_hit = 1'b0;
    logic          busy;
    logic [HW-1:0] food_h;
    logic [VW-1:0] food_v;
    logic          food_valid;
    logic          done;
    logic          grid_full;
`ifdef FOOD_PLACER_STATS_EN
    logic [15:0]   last_attempts;
    logic          scan_used;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit occ_map [H*V];
    int q_cnt = 0;
    int q_h = 0;
    int q_v = 0;

    always #5 mclk = ~mclk;

    food_placer #(
        .H_CELLS  (H),
        .V_CELLS  (V),
        .HW       (HW),
        .VW       (VW),
        .MAX_TRIES(MT)
    ) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .req       (req),
        .ran_h     (ran_h),
        .ran_v     (ran_v),
        .occ_rd    (occ_rd),
        .occ_h     (occ_h),
        .occ_v     (occ_v),
        .occ_valid (occ_valid),
        .occ_hit   (occ_hit),
        .busy      (busy),
        .food_h    (food_h),
        .food_v    (food_v),
        .food_valid(food_valid),
        .done      (done),
        .grid_full (grid_full)
`ifdef FOOD_PLACER_STATS_EN
        ,
        .last_attempts(last_attempts),
        .scan_used    (scan_used)
`endif
    );

    task automatic fill_map(input bit val);
        for (int i = 0; i < H*V; i++) occ_map[i] = val;
    endtask

    // Wait (bounded) for a query, record it, answer after lat cycles from the map.
    task automatic respond_one(input int lat, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (occ_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        total_cnt++;
        if (!ok) $display("FAIL query_timeout: occ_rd=%b required 1", occ_rd);
        else pass_cnt++;
        if (ok) begin
            q_h = int'(occ_h);
            q_v = int'(occ_v);
            q_cnt++;
            repeat (lat) @(negedge mclk);
            total_cnt++;
            if (occ_rd !== 1'b0 || int'(occ_h) != q_h || int'(occ_v) != q_v)
                $display("FAIL wait_hold: occ_rd=%b occ=(%0d,%0d) required 0 (%0d,%0d)",
                         occ_rd, occ_h, occ_v, q_h, q_v);
            else pass_cnt++;
            occ_valid = 1'b1;
            occ_hit   = (q_h < H && q_v < V) ? occ_map[q_v*H + q_h] : 1'b1;
            @(negedge mclk);
            occ_valid = 1'b0;
            occ_hit   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge mclk);
        total_cnt++;
        if ({occ_rd, busy, food_valid, done, grid_full} !== 5'b0 || food_h !== 7'd0 || food_v !== 6'd0)
            $display("FAIL reset_outputs: rd/busy/fv/done/full=%b food=(%0d,%0d) required 0",
                     {occ_rd, busy, food_valid, done, grid_full}, food_h, food_v);
        else pass_cnt++;
`ifdef FOOD_PLACER_STATS_EN
        total_cnt++;
        if (last_attempts !== 16'd0 || scan_used !== 1'b0)
            $display("FAIL reset_stats: last_attempts=%0d scan_used=%b required 0 0", last_attempts, scan_used);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_basic();
        fill_map(1'b0);
        ran_h = 32'hABCD_0005;
        ran_v = 32'h1234_5687;
        req = 1'b1;
        @(negedge mclk);
        req = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || occ_rd !== 1'b0)
            $display("FAIL basic_sample: busy=%b occ_rd=%b required 1 0", busy, occ_rd);
        else pass_cnt++;
        @(negedge mclk);
        total_cnt++;
        if (occ_rd !== 1'b1 || occ_h !== 7'd5 || occ_v !== 6'd7)
            $display("FAIL basic_query: occ_rd=%b occ=(%0d,%0d) required 1 (5,7)", occ_rd, occ_h, occ_v);
        else pass_cnt++;
        @(negedge mclk);
        total_cnt++;
        if (occ_rd !== 1'b0)
            $display("FAIL basic_wait_rd: occ_rd=%b required 0", occ_rd);
        else pass_cnt++;
        occ_valid = 1'b1;
        occ_hit   = 1'b0;
        @(negedge mclk);
        occ_valid = 1'b0;
        total_cnt++;
        if (done !== 1'b1 || food_valid !== 1'b1 || food_h !== 7'd5 || food_v !== 6'd7)
            $display("FAIL basic_done_c4: done=%b fv=%b food=(%0d,%0d) required 1 1 (5,7)",
                     done, food_valid, food_h, food_v);
        else pass_cnt++;
        @(negedge mclk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || food_valid !== 1'b1)
            $display("FAIL basic_after: done=%b busy=%b fv=%b required 0 0 1", done, busy, food_valid);
        else pass_cnt++;
`ifdef FOOD_PLACER_STATS_EN
        total_cnt++;
        if (last_attempts !== 16'd1 || scan_used !== 1'b0)
            $display("FAIL basic_stats: last_attempts=%0d scan_used=%b required 1 0", last_attempts, scan_used);
        else pass_cnt++;
`endif
        repeat (3) @(negedge mclk);
        total_cnt++;
        if (food_valid !== 1'b1 || food_h !== 7'd5 || food_v !== 6'd7)
            $display("FAIL basic_hold: fv=%b food=(%0d,%0d) required 1 (5,7)", food_valid, food_h, food_v);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        bit bad;
        ran_h = 32'd5;
        ran_v = 32'd7;
        req = 1'b1;
        @(negedge mclk);
        req = 1'b0;
        repeat (2) @(negedge mclk);
        rst_n = 1'b0;
        @(negedge mclk);
        rst_n = 1'b1;
        occ_valid = 1'b1;
        occ_hit   = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || food_valid !== 1'b0)
            $display("FAIL rstwait_idle: busy=%b fv=%b required 0 0", busy, food_valid);
        else pass_cnt++;
        @(negedge mclk);
        occ_valid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0 || food_valid !== 1'b0 || busy !== 1'b0 || occ_rd !== 1'b0) bad = 1'b1;
            @(negedge mclk);
        end
        total_cnt++;
        if (bad) $display("FAIL rstwait_late_valid: a late occ_valid changed done/fv/busy/occ_rd, required all 0");
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        bit ok;
        fill_map(1'b0);
        occ_map[0] = 1'b1;
        ran_h = 32'd100;
        ran_v = 32'd7;
        q_cnt = 0;
        req = 1'b1;
        @(negedge mclk);
        req = 1'b0;
        respond_one(2, ok);
        total_cnt++;
        if (q_h != 0 || q_v != 0)
            $display("FAIL oor_first_query: (%0d,%0d) required (0,0)", q_h, q_v);
        else pass_cnt++;
        respond_one(1, ok);
        total_cnt++;
        if (q_h != 1 || q_v != 0 || q_cnt != 2)
            $display("FAIL oor_second_query: (%0d,%0d) count=%0d required (1,0) 2", q_h, q_v, q_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || food_h !== 7'd1 || food_v !== 6'd0)
            $display("FAIL oor_place: done=%b food=(%0d,%0d) required 1 (1,0)", done, food_h, food_v);
        else pass_cnt++;
        @(negedge mclk);
`ifdef FOOD_PLACER_STATS_EN
        total_cnt++;
        if (last_attempts !== 16'd2 || scan_used !== 1'b1)
            $display("FAIL oor_stats: last_attempts=%0d scan_used=%b required 2 1", last_attempts, scan_used);
        else pass_cnt++;
`endif
    endtask

    task automatic test_scan_wrap();
        bit ok;
        fill_map(1'b0);
        occ_map[59*H + 79] = 1'b1;
        ran_h = 32'd79;
        ran_v = 32'd59;
        q_cnt = 0;
        req = 1'b1;
        @(negedge mclk);
        req = 1'b0;
        respond_one(1, ok);
        respond_one(1, ok);
        total_cnt++;
        if (q_h != 79 || q_v != 59)
            $display("FAIL wrap_random_query: (%0d,%0d) required (79,59)", q_h, q_v);
        else pass_cnt++;
        respond_one(1, ok);
        total_cnt++;
        if (q_h != 0 || q_v != 0 || q_cnt != 3)
            $display("FAIL wrap_scan_query: (%0d,%0d) count=%0d required (0,0) 3", q_h, q_v, q_cnt);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b1 || food_valid !== 1'b1 || food_h !== 7'd0 || food_v !== 6'd0)
            $display("FAIL wrap_place: done=%b fv=%b food=(%0d,%0d) required 1 1 (0,0)",
                     done, food_valid, food_h, food_v);
        else pass_cnt++;
        @(negedge mclk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit saw;
        fill_map(1'b0);
        ran_h = 32'd5;
        ran_v = 32'd7;
        total_cnt++;
        if (food_valid !== 1'b1)
            $display("FAIL b2b_pre_valid: fv=%b required 1", food_valid);
        else pass_cnt++;
        req = 1'b1;
        @(negedge mclk);
        total_cnt++;
        if (food_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_fv_drop: fv=%b busy=%b required 0 1", food_valid, busy);
        else pass_cnt++;
        @(negedge mclk);
        req = 1'b0;
        ran_h = 32'd10;
        ran_v = 32'd20;
        q_cnt = 0;
        respond_one(1, ok);
        total_cnt++;
        if (q_h != 5 || q_v != 7 || done !== 1'b1 || food_h !== 7'd5 || food_v !== 6'd7)
            $display("FAIL b2b_place: query=(%0d,%0d) done=%b food=(%0d,%0d) required (5,7) 1 (5,7)",
                     q_h, q_v, done, food_h, food_v);
        else pass_cnt++;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge mclk);
            if (busy !== 1'b0 || occ_rd !== 1'b0) saw = 1'b1;
        end
        total_cnt++;
        if (saw) $display("FAIL b2b_busy_req_dropped: busy or occ_rd rose after done, required 0");
        else pass_cnt++;
    endtask

    task automatic test_grid_full();
        bit ok;
        bit seen;
        fill_map(1'b1);
        ran_h = 32'd79;
        ran_v = 32'd59;
        q_cnt = 0;
        seen = 1'b0;
        req = 1'b1;
        @(negedge mclk);
        req = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            respond_one(1, ok);
            if (!ok) break;
            if (grid_full === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!seen || q_cnt != 4802)
            $display("FAIL full_pulse: grid_full_seen=%b queries=%0d required 1 4802", seen, q_cnt);
        else pass_cnt++;
        total_cnt++;
        if (food_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL full_outputs: fv=%b done=%b required 0 0", food_valid, done);
        else pass_cnt++;
        @(negedge mclk);
        total_cnt++;
        if (grid_full !== 1'b0 || busy !== 1'b0)
            $display("FAIL full_after: grid_full=%b busy=%b required 0 0", grid_full, busy);
        else pass_cnt++;
`ifdef FOOD_PLACER_STATS_EN
        total_cnt++;
        if (last_attempts !== 16'd4802)
            $display("FAIL full_stats: last_attempts=%0d required 4802", last_attempts);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_wait();
        test_out_of_range();
        test_scan_wrap();
        test_back_to_back();
        test_grid_full();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
